pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the 9-bit CPU. It sits directly upstream of the instruction memory and drives its 10-bit `pc` address every cycle. It advances, branches, calls and returns according to one-cycle control strobes from the decoder. It holds a 16-entry subroutine address table (targets for `jtsr`) and a return-address stack (used by `rfsr`), and it owns the run/halt/fault status of the core.

## Interface
- `DEPTH`, 4 — return-stack entries (2..8).
- `clk`  in  1  — single clock; all state updates on rising edge.
- `reset`  in  1  — synchronous, active-high.
- `start`  in  1  — begin execution at pc 0 (honoured in IDLE, HALT, FAULT).
- `stall`  in  1  — hold pc and all state this cycle (lower priority than reset/start).
- `done_req`  in  1  — decoded `done`.
- `ret_req`  in  1  — decoded `rfsr`.
- `jsr_req`  in  1  — decoded `jtsr`.
- `jsr_idx`  in  4  — subroutine number.
- `br_take`  in  1  — `bnzr` condition true.
- `br_target`  in  8  — absolute target (Z register), zero-extended to 10 bits.
- `rel_take`  in  1  — `jizr` condition true.
- `rel_off`  in  3  — forward skip count.
- `tbl_we`  in  1  — write subroutine table.
- `tbl_idx`  in  4  — table entry.
- `tbl_addr`  in  10  — subroutine start address.
- `pc`  out  10  — instruction address to instruction memory.
- `running`  out  1  — state == RUN.
- `done`  out  1  — state == HALT.
- `fault`  out  1  — state == FAULT.
- `sp`  out  4  — current stack occupancy (0..DEPTH).

## Operation
- States: IDLE, RUN, HALT, FAULT. The reset state is IDLE.
- IDLE/HALT/FAULT with `start`=1: pc←0, sp←0, go to RUN. All other inputs are ignored outside RUN, except `tbl_we`.
- In RUN with `stall`=0, exactly one action is taken, by priority:
  1. `done_req`: pc holds, go to HALT.
  2. `ret_req`: if sp==0, go to FAULT with pc held. Otherwise pc←stack[sp-1] and sp−1.
  3. `jsr_req`: if sp==DEPTH, go to FAULT with pc held. Otherwise push pc+1, then pc←table[jsr_idx] and sp+1.
  4. `br_take`: pc←{2'b00, br_target}.
  5. `rel_take`: pc←pc+1+rel_off.
  6. Otherwise: pc←pc+1.
- All pc arithmetic is modulo 1024. 1023+1 wraps to 0. Pushed return addresses wrap the same way.
- `start` asserted while in RUN is ignored.
- `tbl_we` writes table[tbl_idx]←tbl_addr in any state, including RUN. It is independent of `stall`.
- Table read during RUN:
  - The table is read combinationally from registered contents.
  - If `jsr_req` and `tbl_we` target the same index in the same cycle, the jump uses the OLD entry.
- `reset` clears pc, state, sp, all stack entries and all 16 table entries to 0.
- A `reset` mid-subroutine discards the stack. No return is possible afterwards.

## Timing
- pc is registered. The instruction memory reads combinationally, so the instruction at pc is visible in the same cycle.
- Decoder strobes derived from that instruction are sampled at the next rising edge. The new pc appears one cycle later.
- There are no delay slots. Every taken branch, call or return has one-cycle latency: the target instruction is fetched in the cycle following the strobe.
- Reset values: pc=0, running=0, done=0, fault=0, sp=0.
- Status outputs are decoded from registered state, so there is no combinational path from inputs to outputs.
- `stall` freezes pc, sp, stack and state for exactly the cycles it is high.
- `done_req` in the same cycle as `stall`: stall wins, and the halt is taken when stall drops, provided the strobe is still present.
- FAULT and HALT are sticky until `start` or `reset`.

## Test plan
- Sequential run: reset, start, no strobes for 5 cycles → pc 0,1,2,3,4,5; running=1, sp=0.
- Call/return:
  - Setup: table[1]=70, run to pc=20, pulse jsr_req with idx 1.
  - Expected: next pc=70, sp=1.
  - Then pulse ret_req at pc=75 → pc=21, sp=0.
- Branch/skip/wrap:
  - At pc=40, br_take with br_target=9 → pc=9.
  - At pc=12, rel_take with rel_off=3 → pc=16.
  - At pc=1023 with no strobe → pc=0.
- Stack limits:
  - With DEPTH=4, five nested jsr_req → fault=1 after the 5th, pc frozen at the 5th caller, sp=4.
  - After reset and start, ret_req at sp=0 → fault=1.
- Priority/collision:
  - done_req+ret_req+jsr_req in one cycle → HALT, pc unchanged, sp unchanged.
  - jsr_req idx 2 with tbl_we idx 2 addr 300 (old value 100) → pc=100; a following jsr to idx 2 → 300.
- Restart/reset:
  - In HALT, pulse start → pc=0, done=0, running=1.
  - Assert reset while sp=2 at pc=500 → pc=0, sp=0, IDLE, table[*]=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-counter sequencer for the 9-bit CPU. Drives the instruction
//   memory address every cycle and advances, branches, calls and returns
//   according to one-cycle decoder strobes. Owns a 16-entry subroutine
//   address table, a DEPTH-entry return-address stack and the
//   run/halt/fault status of the core.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   start               : begin execution at pc 0 (IDLE/HALT/FAULT only)
//   stall               : freeze pc, sp, stack and state this cycle
//   done_req            : halt strobe
//   ret_req             : return strobe (pop)
//   jsr_req, jsr_idx    : call strobe and subroutine table index
//   br_take, br_target  : absolute branch to zero-extended target
//   rel_take, rel_off   : forward skip, pc <- pc + 1 + rel_off
//   tbl_we/idx/addr     : subroutine table write port (any state)
//   pc                  : registered instruction address
//   running/done/fault  : state decode (RUN / HALT / FAULT)
//   sp                  : return-stack occupancy, 0..DEPTH
module pc_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stall,
    input  logic       done_req,
    input  logic       ret_req,
    input  logic       jsr_req,
    input  logic [3:0] jsr_idx,
    input  logic       br_take,
    input  logic [7:0] br_target,
    input  logic       rel_take,
    input  logic [2:0] rel_off,
    input  logic       tbl_we,
    input  logic [3:0] tbl_idx,
    input  logic [9:0] tbl_addr,
    output logic [9:0] pc,
    output logic       running,
    output logic       done,
    output logic       fault,
    output logic [3:0] sp
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t     state, state_n;
    logic [9:0] pc_n;
    logic [3:0] sp_n;
    logic       push;
    logic [9:0] pc_inc;
    logic [9:0] stk_top;

    logic [9:0] stack [DEPTH];
    logic [9:0] tbl   [16];

    assign pc_inc = pc + 10'd1;

    // Top-of-stack read: entry sp-1, selected without arithmetic on sp
    // so an empty stack simply yields 0 (never used: ret at sp==0 faults).
    always_comb begin
        stk_top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp == 4'(i + 1)) stk_top = stack[i];
        end
    end

    // State / pc / sp / stack / table registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            pc    <= '0;
            sp    <= '0;
            for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
            for (int i = 0; i < 16; i++)    tbl[i]   <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            sp    <= sp_n;
            for (int i = 0; i < DEPTH; i++) begin
                if (push && sp == 4'(i)) stack[i] <= pc_inc;
            end
            // Table write is independent of state and stall. A jsr in the
            // same cycle already latched the old entry through pc_n.
            if (tbl_we) tbl[tbl_idx] <= tbl_addr;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        pc_n    = pc;
        sp_n    = sp;
        push    = 1'b0;
        case (state)
            S_RUN: begin
                if (!stall) begin
                    if (done_req) begin
                        state_n = S_HALT;
                    end else if (ret_req) begin
                        if (sp == 4'd0) begin
                            state_n = S_FAULT;
                        end else begin
                            pc_n = stk_top;
                            sp_n = sp - 4'd1;
                        end
                    end else if (jsr_req) begin
                        if (sp == 4'(DEPTH)) begin
                            state_n = S_FAULT;
                        end else begin
                            push = 1'b1;
                            pc_n = tbl[jsr_idx];
                            sp_n = sp + 4'd1;
                        end
                    end else if (br_take) begin
                        pc_n = {2'b00, br_target};
                    end else if (rel_take) begin
                        pc_n = pc_inc + {7'd0, rel_off};
                    end else begin
                        pc_n = pc_inc;
                    end
                end
            end
            default: begin
                // IDLE, HALT, FAULT: only start leaves; it wins over stall.
                if (start) begin
                    state_n = S_RUN;
                    pc_n    = '0;
                    sp_n    = '0;
                end
            end
        endcase
    end

    // Status outputs, decoded from registered state only
    always_comb begin
        running = 1'b0;
        done    = 1'b0;
        fault   = 1'b0;
        case (state)
            S_RUN:   running = 1'b1;
            S_HALT:  done    = 1'b1;
            S_FAULT: fault   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
    localparam int DEPTH = 4;

    logic       clk = 0;
    logic       reset, start, stall, done_req, ret_req, jsr_req;
    logic [3:0] jsr_idx, tbl_idx;
    logic       br_take, rel_take, tbl_we;
    logic [7:0] br_target;
    logic [2:0] rel_off;
    logic [9:0] tbl_addr;
    logic [9:0] pc;
    logic       running, done, fault;
    logic [3:0] sp;

    pc_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .done_req(done_req), .ret_req(ret_req), .jsr_req(jsr_req),
        .jsr_idx(jsr_idx), .br_take(br_take), .br_target(br_target),
        .rel_take(rel_take), .rel_off(rel_off), .tbl_we(tbl_we),
        .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .pc(pc),
        .running(running), .done(done), .fault(fault), .sp(sp)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: plain integers, a queue for the stack, an array
    // for the table. 0=IDLE 1=RUN 2=HALT 3=FAULT.
    int m_pc, m_st;
    int m_tbl [16];
    int m_stk [$];

    function automatic void model_step();
        int jt;
        if (reset) begin
            m_pc = 0; m_st = 0; m_stk.delete();
            for (int i = 0; i < 16; i++) m_tbl[i] = 0;
            return;
        end
        jt = m_tbl[jsr_idx];
        if (m_st != 1) begin
            if (start) begin m_pc = 0; m_stk.delete(); m_st = 1; end
        end else if (!stall) begin
            if (done_req) m_st = 2;
            else if (ret_req) begin
                if (m_stk.size() == 0) m_st = 3;
                else m_pc = m_stk.pop_back();
            end else if (jsr_req) begin
                if (m_stk.size() == DEPTH) m_st = 3;
                else begin m_stk.push_back((m_pc + 1) % 1024); m_pc = jt; end
            end else if (br_take) m_pc = br_target;
            else if (rel_take) m_pc = (m_pc + 1 + rel_off) % 1024;
            else m_pc = (m_pc + 1) % 1024;
        end
        if (tbl_we) m_tbl[tbl_idx] = tbl_addr;
    endfunction

    task automatic clr();
        reset = 0; start = 0; stall = 0; done_req = 0; ret_req = 0;
        jsr_req = 0; jsr_idx = 0; br_take = 0; br_target = 0;
        rel_take = 0; rel_off = 0; tbl_we = 0; tbl_idx = 0; tbl_addr = 0;
    endtask

    // One clock: model advances on the same edge, outputs sampled 1ns later,
    // then strobes are dropped.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("pc", pc, m_pc);
        chk("sp", sp, m_stk.size());
        chk("running", running, m_st == 1);
        chk("done", done, m_st == 2);
        chk("fault", fault, m_st == 3);
        clr();
    endtask

    task automatic goto_pc(input int a);   // absolute branch helper (a < 256)
        br_take = 1; br_target = 8'(a); tick();
    endtask

    task automatic wr_tbl(input int idx, input int a);
        tbl_we = 1; tbl_idx = 4'(idx); tbl_addr = 10'(a); tick();
    endtask

    task automatic jsr(input int idx);
        jsr_req = 1; jsr_idx = 4'(idx); tick();
    endtask

    initial begin
        clr();
        #2;
        // Reset state
        reset = 1; tick();
        chk("rst_pc", pc, 0); chk("rst_sp", sp, 0);
        chk("rst_run", running, 0); chk("rst_done", done, 0); chk("rst_fault", fault, 0);

        // Sequential run
        start = 1; tick();
        chk("start_pc", pc, 0); chk("start_run", running, 1);
        for (int i = 1; i <= 5; i++) begin tick(); chk("seq_pc", pc, i); end

        // start while running is ignored
        start = 1; tick(); chk("start_in_run", pc, 6);

        // Call / return
        wr_tbl(1, 70);
        goto_pc(20); chk("at20", pc, 20);
        jsr(1); chk("call_pc", pc, 70); chk("call_sp", sp, 1);
        repeat (5) tick(); chk("at75", pc, 75);
        ret_req = 1; tick(); chk("ret_pc", pc, 21); chk("ret_sp", sp, 0);

        // Branch / skip / wrap
        goto_pc(40); goto_pc(9); chk("br_pc", pc, 9);
        goto_pc(12); rel_take = 1; rel_off = 3; tick(); chk("rel_pc", pc, 16);
        wr_tbl(3, 1023); jsr(3); chk("at1023", pc, 1023);
        tick(); chk("wrap_pc", pc, 0);
        ret_req = 1; tick(); chk("ret_after_wrap", pc, 18);
        // Return address wrap: call from 1023
        wr_tbl(6, 1022); jsr(6); tick(); chk("at1023b", pc, 1023);
        wr_tbl(7, 50); chk("tblwr_pc", pc, 0);
        goto_pc(0);
        jsr(3); jsr(7); chk("nest_pc", pc, 50);
        ret_req = 1; tick(); chk("ret_wrap_addr", pc, 0);

        // Stall freezes; done under stall waits for stall to drop
        stall = 1; done_req = 1; tick(); chk("stall_pc", pc, 0); chk("stall_run", running, 1);
        stall = 1; tick(); chk("stall_pc2", pc, 0);
        done_req = 1; tick(); chk("halt_after_stall", done, 1);
        tick(); chk("halt_sticky", pc, 0);

        // Restart from HALT
        start = 1; tick(); chk("restart_pc", pc, 0); chk("restart_done", done, 0);
        chk("restart_run", running, 1);

        // Stack overflow
        wr_tbl(4, 200);
        for (int i = 0; i < 4; i++) jsr(4);
        chk("ovf_sp4", sp, 4);
        jsr(4); chk("ovf_fault", fault, 1); chk("ovf_pc", pc, 200); chk("ovf_sp", sp, 4);
        tick(); chk("fault_sticky", fault, 1);

        // Underflow after reset + start
        reset = 1; tick(); start = 1; tick();
        ret_req = 1; tick(); chk("unf_fault", fault, 1); chk("unf_pc", pc, 0);

        // Priority: done beats ret/jsr
        start = 1; tick(); goto_pc(33);
        done_req = 1; ret_req = 1; jsr_req = 1; tick();
        chk("prio_halt", done, 1); chk("prio_pc", pc, 33); chk("prio_sp", sp, 0);

        // Same-cycle jsr / table write uses the old entry
        start = 1; tick(); wr_tbl(2, 100);
        jsr_req = 1; jsr_idx = 2; tbl_we = 1; tbl_idx = 2; tbl_addr = 300; tick();
        chk("coll_old", pc, 100);
        jsr(2); chk("coll_new", pc, 300);

        // Reset mid-subroutine clears table and stack
        reset = 1; tick(); start = 1; tick();
        wr_tbl(1, 70); wr_tbl(5, 500);
        jsr(1); jsr(5); chk("pre_rst_pc", pc, 500); chk("pre_rst_sp", sp, 2);
        reset = 1; tick();
        chk("rst2_pc", pc, 0); chk("rst2_sp", sp, 0); chk("rst2_run", running, 0);
        start = 1; tick(); goto_pc(10);
        jsr(5); chk("tbl5_clr", pc, 0);
        jsr(1); chk("tbl1_clr", pc, 0);
        jsr(3); chk("tbl3_clr", pc, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 299) == 0);
            start    = ($urandom_range(0, 7) == 0);
            stall    = ($urandom_range(0, 7) == 0);
            done_req = ($urandom_range(0, 59) == 0);
            ret_req  = ($urandom_range(0, 5) == 0);
            jsr_req  = ($urandom_range(0, 5) == 0);
            jsr_idx  = 4'($urandom);
            br_take  = ($urandom_range(0, 7) == 0);
            br_target = 8'($urandom);
            rel_take = ($urandom_range(0, 5) == 0);
            rel_off  = 3'($urandom);
            tbl_we   = ($urandom_range(0, 3) == 0);
            tbl_idx  = 4'($urandom);
            tbl_addr = 10'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
